ip_uart_rx: RTL
===============

IP_UART_RX -- requirements
Module: ip_uart_rx

Interface
REQ-001 Parameter clk_freq, default 43200000, clk frequency in Hz.
REQ-002 Parameter uart_freq, default 115200, baud rate in bps.
REQ-003 Parameter io_base, default 8'h20, I/O base address; data port = io_base, status/control port = io_base+1.
REQ-004 clk  input  1  system clock; one clock domain; reset is synchronous and active-low.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 enable  input  1  clock enable; all baud timing advances only on cycles with enable=1.
REQ-007 iorq_n  input  1  Z80 I/O request, active low.
REQ-008 rd_n  input  1  Z80 read strobe, active low.
REQ-009 wr_n  input  1  Z80 write strobe, active low.
REQ-010 a  input  8  Z80 I/O address a[7:0].
REQ-011 d  input  8  Z80 write data.
REQ-012 q  output  8  read data.
REQ-013 q_en  output  1  read data valid; drives the top-level data-bus mux.
REQ-014 uart_rx  input  1  asynchronous serial input, idle high.

Function
REQ-015 uart_rx SHALL pass a 2-flop synchronizer; both flops reset to 1.
REQ-016 BIT_CNT = clk_freq/(2*uart_freq) rounded down (187 at defaults); HALF = BIT_CNT/2 (93); counts are in enabled cycles.
REQ-017 RX FSM states IDLE, START, DATA, STOP; reset state IDLE.
REQ-018 IDLE->START on synced falling edge (previous 1, current 0); bit counter cleared.
REQ-019 START: at count HALF, sample; 1 -> IDLE (glitch, nothing stored); 0 -> DATA, counter cleared.
REQ-020 DATA: sample every BIT_CNT counts, LSB first; after 8th bit -> STOP.
REQ-021 STOP: sample after BIT_CNT counts; 1 -> push byte to FIFO, IDLE; 0 -> set framing-error flag, discard byte, IDLE.
REQ-022 A line held low after framing error SHALL NOT restart reception until a 1->0 edge occurs.
REQ-023 FIFO 16x8; push when full discards the byte and sets overflow flag.
REQ-024 Push and pop in the same cycle both take effect, including when full; count unchanged, no overflow.
REQ-025 q_en = !iorq_n && !rd_n && (a==io_base || a==io_base+1), combinational.
REQ-026 Data port read: q = FIFO head; 8'hFF when empty.
REQ-027 Status read: q = {5'b0, framing_err, overflow, !empty}.
REQ-028 Pop occurs once per data-port read, in the first cycle after the matched read access ends (iorq_n or rd_n high); empty read pops nothing.
REQ-029 Status write (a==io_base+1, !iorq_n, !wr_n): d[1]=1 clears overflow, d[2]=1 clears framing_err, d[7]=1 flushes FIFO; acted on once per write access.
REQ-030 Flush coincident with push: flush wins, FIFO empty afterwards.
REQ-031 q SHALL be 8'h00 when q_en=0.

Reset
REQ-032 reset_n=0 for one clk edge: FSM IDLE, FIFO empty, pointers 0, flags 0, shift register 0, counters 0.
REQ-033 Reset mid-frame SHALL abort the frame; no partial byte is pushed.
REQ-034 Reset is honoured regardless of enable.

Structure
REQ-035 No shared package; BIT_CNT, HALF, state encodings and port offsets are localparams in ip_uart_rx.
REQ-036 One sub-module ip_uart_rx_fifo (16x8, push/pop/flush, full/empty) instantiated once.

Verification
REQ-037 enable=1 every other cycle, send 0x55 at 115200 -> status reads 8'h01, data read 0x55, then status 8'h00.
REQ-038 Send 17 bytes 0x00..0x10 without reads -> status 8'h03; 16 reads return 0x00..0x0F; 17th read 0xFF.
REQ-039 Send 0xA5 with stop bit 0 -> status 8'h04, FIFO empty; write 8'h04 to io_base+1 -> status 8'h00.
REQ-040 Low pulse of 40 enabled cycles on idle line -> FSM back to IDLE, status 8'h00.
REQ-041 FIFO full, data read ending on the same cycle a new stop bit is accepted -> count stays 16, overflow stays 0.
REQ-042 reset_n=0 during DATA bit 4 of 0x3C -> status 8'h00 after reset; next 0x3C received correctly.

Source files
------------

// File: rtl/ip_uart_rx_fifo.sv
// ip_uart_rx_fifo: small synchronous FIFO holding received UART bytes.
// Push and pop in the same cycle both take effect even when full.
// Flush empties the FIFO and overrides a coincident push.
module ip_uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] pushData_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign headData_o = mem_q[rdPtr_q];
    assign doPop      = pop_i && !empty_o;
    assign doPush     = push_i && (!full_o || doPop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Pointer and occupancy bookkeeping, flush taking priority over push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ip_uart_rx.sv
// ip_uart_rx: Z80 I/O mapped UART receiver with a 16-byte receive FIFO.
// Data port at io_base returns the FIFO head; status/control at io_base+1.
module ip_uart_rx #(
    parameter int         clk_freq  = 43200000,
    parameter int         uart_freq = 115200,
    parameter logic [7:0] io_base   = 8'h20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] a,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       q_en,
    input  logic       uart_rx
);

    // Counts are in enabled cycles; enable runs at half the clock rate.
    localparam int         BIT_CNT     = clk_freq / (2 * uart_freq);
    localparam int         HALF        = BIT_CNT / 2;
    localparam int         CNT_W       = $clog2(BIT_CNT + 1);
    localparam logic [7:0] DATA_PORT   = io_base;
    localparam logic [7:0] STATUS_PORT = io_base + 8'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    rxState_t   rxState_q;
    logic [CNT_W-1:0] bitCount_q;
    logic [2:0] bitIndex_q;
    logic [7:0] shift_q;
    logic       push_q;
    logic       frameErrSet_q;
    logic       rxMeta_q;
    logic       rxSync_q;
    logic       rxPrev_q;

    logic       overflow_q;
    logic       framingErr_q;
    logic       rdActive_q;
    logic       rdNonEmpty_q;
    logic       wrActive_q;

    logic       dataRead;
    logic       statusWrite;
    logic       popFire;
    logic       writeFire;
    logic       flushFire;
    logic [7:0] fifoHead;
    logic       fifoFull;
    logic       fifoEmpty;
    logic       unusedDataBits;

    assign dataRead    = !iorq_n && !rd_n && (a == DATA_PORT);
    assign statusWrite = !iorq_n && !wr_n && (a == STATUS_PORT);
    assign popFire     = rdActive_q && !dataRead && rdNonEmpty_q;
    assign writeFire   = statusWrite && !wrActive_q;
    assign flushFire   = writeFire && d[7];
    assign q_en        = !iorq_n && !rd_n && ((a == DATA_PORT) || (a == STATUS_PORT));
    assign unusedDataBits = ^{d[6:3], d[0]};

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= uart_rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Receive FSM: start-bit qualification, 8 data bits LSB first, stop check.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxState_q     <= IDLE;
            bitCount_q    <= '0;
            bitIndex_q    <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            frameErrSet_q <= 1'b0;
            rxPrev_q      <= 1'b1;
        end else begin
            push_q        <= 1'b0;
            frameErrSet_q <= 1'b0;
            if (enable) begin
                rxPrev_q <= rxSync_q;
                case (rxState_q)
                    IDLE: begin
                        if (rxPrev_q && !rxSync_q) begin
                            rxState_q  <= START;
                            bitCount_q <= '0;
                        end
                    end
                    START: begin
                        if (bitCount_q == CNT_W'(HALF)) begin
                            bitCount_q <= '0;
                            bitIndex_q <= '0;
                            rxState_q  <= rxSync_q ? IDLE : DATA;
                        end else begin
                            bitCount_q <= bitCount_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bitCount_q == CNT_W'(BIT_CNT - 1)) begin
                            bitCount_q <= '0;
                            shift_q    <= {rxSync_q, shift_q[7:1]};
                            bitIndex_q <= bitIndex_q + 1'b1;
                            if (bitIndex_q == 3'd7) begin
                                rxState_q <= STOP;
                            end
                        end else begin
                            bitCount_q <= bitCount_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bitCount_q == CNT_W'(BIT_CNT - 1)) begin
                            bitCount_q <= '0;
                            rxState_q  <= IDLE;
                            if (rxSync_q) begin
                                push_q <= 1'b1;
                            end else begin
                                frameErrSet_q <= 1'b1;
                            end
                        end else begin
                            bitCount_q <= bitCount_q + 1'b1;
                        end
                    end
                    default: rxState_q <= IDLE;
                endcase
            end
        end
    end

    // Bus access tracking so a data read pops once and a write acts once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdActive_q   <= 1'b0;
            rdNonEmpty_q <= 1'b0;
            wrActive_q   <= 1'b0;
        end else begin
            rdActive_q   <= dataRead;
            rdNonEmpty_q <= dataRead && !fifoEmpty;
            wrActive_q   <= statusWrite;
        end
    end

    // Sticky error flags; a new error event wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow_q   <= 1'b0;
            framingErr_q <= 1'b0;
        end else begin
            if (push_q && fifoFull && !popFire && !flushFire) begin
                overflow_q <= 1'b1;
            end else if (writeFire && d[1]) begin
                overflow_q <= 1'b0;
            end
            if (frameErrSet_q) begin
                framingErr_q <= 1'b1;
            end else if (writeFire && d[2]) begin
                framingErr_q <= 1'b0;
            end
        end
    end

    // Read-data mux; drives zero whenever this block is not being read.
    always_comb begin
        q = 8'h00;
        if (q_en) begin
            if (a == DATA_PORT) begin
                q = fifoEmpty ? 8'hFF : fifoHead;
            end else begin
                q = {5'b0, framingErr_q, overflow_q, !fifoEmpty};
            end
        end
    end

    ip_uart_rx_fifo #(
        .DEPTH(16),
        .WIDTH(8)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push_q),
        .pop_i      (popFire),
        .flush_i    (flushFire),
        .pushData_i (shift_q),
        .headData_o (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

endmodule
